cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
Coprocessor-0 for the 5-stage MIPS core; sits in the M stage beside the bridge.
- Holds SR, Cause, EPC and PRId.
- Arbitrates hardware interrupts and synchronous exceptions, and raises IntReq. IntReq drives the PC mux's int_PC_sel, which redirects fetch to 0x0000_4180.
- Supplies EPC to the PC mux for eret.
- Supplies Dout for mfc0; Dout is pipelined to W and selected into DMOUT_W by the CP0 select.

Parameters:
PRID_VALUE, 32'h4D49_5053, constant returned for reads of register 15 (PRId).

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
A1  in  5  mfc0 read register number
A2  in  5  mtc0 write register number
Din  in  32  mtc0 write data (RT value in M)
We  in  1  mtc0 write enable
VPC  in  32  PC of the instruction in M (victim PC)
BD  in  1  instruction in M sits in a branch delay slot
ExcCode  in  5  synchronous exception code from M; 0 means no exception
HWInt  in  6  hardware interrupt lines [7:2] (timer0, timer1, external, ...)
EXLClr  in  1  eret is in M
IntReq  out  1  take exception/interrupt this cycle (flush + vector)
EPC  out  32  current EPC register value
Dout  out  32  read data for A1

Behaviour:
Registers and fields:
- SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
- EPC (14): full 32 bits, bits [1:0] always 0.
- PRId (15): reads PRID_VALUE.
- Any other A1 reads 0.

Reset:
- Asynchronous on reset_n low: SR = 0, Cause = 0, EPC = 0.
- Outputs during reset: IntReq = 0, EPC = 0, Dout = 0 except when A1 = 15.

IP sampling:
- Cause.IP <= HWInt every cycle, unconditionally, including during EXL.

Request logic (combinational from current state and inputs):
- int_hit = |(HWInt & SR.IM) & SR.IE & !SR.EXL
- exc_hit = (ExcCode != 0) & !SR.EXL
- IntReq = int_hit | exc_hit

Entry (clock edge where IntReq = 1):
- SR.EXL <= 1.
- Cause.BD <= BD.
- EPC <= (BD ? VPC-4 : VPC) & ~3, computed mod 2^32.
- Cause.ExcCode <= int_hit ? 0 : ExcCode. Interrupt has priority over a simultaneous exception.

Priority on a single edge:
- Entry beats mtc0 and EXLClr. The concurrent We write and EXLClr are dropped; the pipeline flushes that instruction.
- EXLClr without entry: SR.EXL <= 0.
- mtc0 without entry: writes only SR.IM/EXL/IE, or all of EPC (low 2 bits forced 0). Writes to Cause, PRId and unimplemented numbers are ignored.
- mtc0 to SR together with EXLClr: EXLClr wins for EXL; the other SR fields take Din.

Timing:
- Reads are combinational from register state; no write-to-read bypass. A value written this cycle is visible next cycle.
- IntReq is asserted in the same cycle as its cause; state updates at the following edge.
- With EXL = 1, IntReq stays 0 (no nesting) until eret.
- Reset mid-entry: the asynchronous reset overrides everything.

Optional Feature:
Macro CP0_TIMER_EN.
- Defined:
  - Adds Count (9) and Compare (11), both readable.
  - Count increments by 1 every cycle and wraps at 2^32.
  - mtc0 to 9 loads Count; mtc0 to 11 loads Compare and clears the pending timer bit.
  - When Count == Compare, a pending bit sets. It is ORed into IP[7] and HWInt[7] path for int_hit.
  - Count, Compare and the pending bit reset to 0.
- Not defined: registers 9 and 11 read 0; writes to them are ignored; IP[7] follows HWInt[7] only.

Decomposition:
Shared package, cp0_pkg:
- register numbers: SR = 12, CAUSE = 13, EPC = 14, PRID = 15, COUNT = 9, COMPARE = 11
- field ranges: IM 15:10, IP 15:10, ExcCode 6:2, BD 31, EXL 1, IE 0
- exception codes: Int = 0, AdEL = 4, AdES = 5, RI = 10, Ov = 12
- handler vector 32'h0000_4180

Sub-module: cp0_timer (Count/Compare/pending) is natural, instantiated only under CP0_TIMER_EN. The rest stays flat.

Test Plan:
- reset_n low mid-run -> SR, Cause and EPC all 0 immediately; IntReq = 0; Dout(A1 = 15) = PRID_VALUE.
- mtc0 SR = 0x0000_FC01, then HWInt = 6'b000100 at VPC = 0x3010, BD = 0 -> IntReq = 1 that cycle; next cycle EXL = 1, EPC = 0x3010, Cause = 0x0000_1000 (IP4, ExcCode 0).
- ExcCode = 12 at VPC = 0x3024, BD = 1 -> EPC = 0x3020; Cause = 0x8000_0030; a second ExcCode while EXL = 1 gives IntReq = 0.
- Interrupt and ExcCode = 4 in the same cycle -> ExcCode field = 0; We to EPC in that cycle is dropped.
- EXLClr with pending enabled HWInt -> EXL cleared at the edge; IntReq = 1 on the next cycle.
- CP0_TIMER_EN: Compare = 5, IM[7] = 1, IE = 1 -> IntReq when Count reaches 5; mtc0 Compare clears the pending bit.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 unit: register numbers, field
// positions, exception codes and the handler vector.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int EXC_HI  = 6;
  localparam int EXC_LO  = 2;
  localparam int BD_BIT  = 31;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  localparam logic [31:0] HANDLER_VECTOR = 32'h0000_4180;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] sr_word(input sr_t s);
    sr_word                = '0;
    sr_word[IM_HI:IM_LO]   = s.im;
    sr_word[EXL_BIT]       = s.exl;
    sr_word[IE_BIT]        = s.ie;
  endfunction

  function automatic logic [31:0] cause_word(input cause_t c);
    cause_word                 = '0;
    cause_word[BD_BIT]         = c.bd;
    cause_word[IP_HI:IP_LO]    = c.ip;
    cause_word[EXC_HI:EXC_LO]  = c.exc_code;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for coprocessor-0; only present when CP0_TIMER_EN is
// defined. Count free-runs, and a match with Compare latches a pending bit.
`ifdef CP0_TIMER_EN
module cp0_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_count,
  input  logic        load_compare,
  input  logic [31:0] data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      compare <= '0;
      pending <= 1'b0;
    end else begin
      count <= load_count ? data : count + 32'd1;
      if (load_compare) begin
        compare <= data;
      end
      // A Compare write acknowledges the timer, even on the matching cycle.
      pending <= load_compare ? 1'b0 : (pending | (count == compare));
    end
  end

endmodule
`endif

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the 5-stage MIPS core: SR, Cause, EPC, PRId, interrupt and
// exception arbitration. Define CP0_TIMER_EN to add the Count/Compare timer.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h4D49_5053
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        We,
  input  logic [31:0] VPC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] Dout
);

  sr_t         sr_q;
  cause_t      cause_q;
  logic [31:0] epc_q;

  logic [5:0]  irq_lines;
  logic        int_hit;
  logic        exc_hit;
  logic        take;
  logic [31:0] victim;
  logic        unused_bits;

`ifdef CP0_TIMER_EN
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        timer_pending;

  // Timer writes lose to an exception entry exactly like SR/EPC writes.
  cp0_timer u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_count   (We && !take && (A2 == REG_COUNT)),
    .load_compare (We && !take && (A2 == REG_COMPARE)),
    .data         (Din),
    .count        (count_val),
    .compare      (compare_val),
    .pending      (timer_pending)
  );

  // The timer shares IP[7] (top HWInt line) with the external source.
  assign irq_lines = {HWInt[5] | timer_pending, HWInt[4:0]};
`else
  assign irq_lines = HWInt;
`endif

  assign int_hit = (|(irq_lines & sr_q.im)) & sr_q.ie & ~sr_q.exl;
  assign exc_hit = (ExcCode != 5'd0) & ~sr_q.exl;
  assign take    = int_hit | exc_hit;

  // Held low while in reset even if ExcCode is active.
  assign IntReq  = reset_n & take;

  // A branch-delay-slot victim restarts at the branch itself.
  assign victim  = BD ? (VPC - 32'd4) : VPC;
  assign EPC     = epc_q;

  assign unused_bits = &{1'b0, victim[1:0], Din[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      cause_q.ip <= irq_lines;
      if (take) begin
        sr_q.exl         <= 1'b1;
        cause_q.bd       <= BD;
        cause_q.exc_code <= int_hit ? 5'(EXC_INT) : ExcCode;
        epc_q            <= {victim[31:2], 2'b00};
      end else begin
        if (We && (A2 == REG_SR)) begin
          sr_q.im  <= Din[IM_HI:IM_LO];
          sr_q.exl <= Din[EXL_BIT];
          sr_q.ie  <= Din[IE_BIT];
        end
        if (We && (A2 == REG_EPC)) begin
          epc_q <= {Din[31:2], 2'b00};
        end
        // NOTE: the later non-blocking assignment to the same bit wins, which
        // gives eret priority over a simultaneous mtc0 to SR for EXL only.
        if (EXLClr) begin
          sr_q.exl <= 1'b0;
        end
      end
    end
  end

  // NOTE: Dout gets a default before the case so no latch is inferred for
  // unimplemented register numbers.
  always_comb begin
    Dout = '0;
    case (A1)
      REG_SR:      Dout = sr_word(sr_q);
      REG_CAUSE:   Dout = cause_word(cause_q);
      REG_EPC:     Dout = epc_q;
      REG_PRID:    Dout = PRID_VALUE;
`ifdef CP0_TIMER_EN
      REG_COUNT:   Dout = count_val;
      REG_COMPARE: Dout = compare_val;
`endif
      default:     Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus a randomized run
// against a word-level reference model. Honours CP0_TIMER_EN like the RTL.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h4D49_5053;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] Din;
  logic        We;
  logic [31:0] VPC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] Dout;

  int checks = 0;
  int errors = 0;

  cp0_unit #(.PRID_VALUE(PRID)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A1      (A1),
    .A2      (A2),
    .Din     (Din),
    .We      (We),
    .VPC     (VPC),
    .BD      (BD),
    .ExcCode (ExcCode),
    .HWInt   (HWInt),
    .EXLClr  (EXLClr),
    .IntReq  (IntReq),
    .EPC     (EPC),
    .Dout    (Dout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    We = 1'b0; ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b0; BD = 1'b0;
    A1 = 5'd0; A2 = 5'd0; Din = 32'd0; VPC = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    A2 = r; Din = d; We = 1'b1;
    tick();
    We = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    A1 = r;
    #1;
    v = Dout;
  endtask

  // Park Compare far away so the post-reset match does not leave a timer
  // interrupt pending (a no-op write without the timer).
  task automatic apply_reset;
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    mtc0(5'd11, 32'hFFFF_FFFF);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    read_reg(5'd12, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_sr got %h want %h", v, 32'd0); end
    read_reg(5'd13, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_cause got %h want %h", v, 32'd0); end
    checks++;
    if (EPC !== 32'd0 || IntReq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got epc=%h intreq=%b want 0/0", EPC, IntReq);
    end
  endtask

  task automatic test_intr_entry;
    logic [31:0] v;
    mtc0(5'd12, 32'h0000_FC01);
    read_reg(5'd12, v); checks++;
    if (v !== 32'h0000_FC01) begin errors++; $display("FAIL sr_write got %h want %h", v, 32'h0000_FC01); end
    HWInt = 6'b000100; VPC = 32'h3010; BD = 1'b0;
    #1; checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL int_req got %b want 1", IntReq); end
    tick();
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL int_no_nest got %b want 0", IntReq); end
    read_reg(5'd12, v); checks++;
    if (v !== 32'h0000_FC03) begin errors++; $display("FAIL int_sr got %h want %h", v, 32'h0000_FC03); end
    read_reg(5'd13, v); checks++;
    if (v !== 32'h0000_1000) begin errors++; $display("FAIL int_cause got %h want %h", v, 32'h0000_1000); end
    checks++;
    if (EPC !== 32'h3010) begin errors++; $display("FAIL int_epc got %h want %h", EPC, 32'h3010); end
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    read_reg(5'd12, v); checks++;
    if (v !== 32'h0000_FC01) begin errors++; $display("FAIL eret_sr got %h want %h", v, 32'h0000_FC01); end
  endtask

  task automatic test_exc_bd;
    logic [31:0] v;
    ExcCode = 5'd12; VPC = 32'h3024; BD = 1'b1;
    #1; checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL exc_req got %b want 1", IntReq); end
    tick();
    read_reg(5'd13, v); checks++;
    if (v !== 32'h8000_0030) begin errors++; $display("FAIL exc_cause got %h want %h", v, 32'h8000_0030); end
    checks++;
    if (EPC !== 32'h3020) begin errors++; $display("FAIL exc_epc got %h want %h", EPC, 32'h3020); end
    ExcCode = 5'd4; VPC = 32'h3028; BD = 1'b0;
    #1; checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL exc_in_exl got %b want 0", IntReq); end
    tick();
    checks++;
    if (EPC !== 32'h3020) begin errors++; $display("FAIL exc_epc_hold got %h want %h", EPC, 32'h3020); end
    ExcCode = 5'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
  endtask

  task automatic test_priority;
    logic [31:0] v;
    HWInt = 6'b000001; ExcCode = 5'd4; VPC = 32'h4000; BD = 1'b0;
    We = 1'b1; A2 = 5'd14; Din = 32'hDEAD_BEE0;
    #1; checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL prio_req got %b want 1", IntReq); end
    tick();
    We = 1'b0; ExcCode = 5'd0;
    read_reg(5'd13, v); checks++;
    if (v !== 32'h0000_0400) begin errors++; $display("FAIL prio_cause got %h want %h", v, 32'h0000_0400); end
    checks++;
    if (EPC !== 32'h4000) begin errors++; $display("FAIL prio_epc got %h want %h", EPC, 32'h4000); end
  endtask

  // Entered from test_priority with EXL = 1 and HWInt[0] still high.
  task automatic test_eret_reentry;
    logic [31:0] v;
    #1; checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL eret_pre got %b want 0", IntReq); end
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0; VPC = 32'h5008;
    #1; checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL eret_reentry got %b want 1", IntReq); end
    tick();
    checks++;
    if (EPC !== 32'h5008) begin errors++; $display("FAIL reentry_epc got %h want %h", EPC, 32'h5008); end
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    read_reg(5'd12, v); checks++;
    if (v !== 32'h0000_FC01) begin errors++; $display("FAIL eret_final got %h want %h", v, 32'h0000_FC01); end
  endtask

  task automatic test_mtc0;
    logic [31:0] v;
    mtc0(5'd13, 32'hFFFF_FFFF);
    mtc0(5'd15, 32'h0000_0000);
    read_reg(5'd13, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL cause_ro got %h want %h", v, 32'd0); end
    read_reg(5'd15, v); checks++;
    if (v !== PRID) begin errors++; $display("FAIL prid got %h want %h", v, PRID); end
    mtc0(5'd14, 32'h1234_5677);
    read_reg(5'd14, v); checks++;
    if (v !== 32'h1234_5674 || EPC !== 32'h1234_5674) begin
      errors++; $display("FAIL epc_write got dout=%h epc=%h want %h", v, EPC, 32'h1234_5674);
    end
    EXLClr = 1'b1;
    mtc0(5'd12, 32'h0000_5403);
    EXLClr = 1'b0;
    read_reg(5'd12, v); checks++;
    if (v !== 32'h0000_5401) begin errors++; $display("FAIL sr_with_eret got %h want %h", v, 32'h0000_5401); end
    mtc0(5'd12, 32'hFFFF_FFFE);
    read_reg(5'd12, v); checks++;
    if (v !== 32'h0000_FC02) begin errors++; $display("FAIL sr_mask got %h want %h", v, 32'h0000_FC02); end
    mtc0(5'd12, 32'h0000_FC01);
    read_reg(5'd3, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL unimpl_read got %h want %h", v, 32'd0); end
`ifndef CP0_TIMER_EN
    mtc0(5'd9, 32'h0000_0077);
    mtc0(5'd11, 32'h0000_0055);
    read_reg(5'd9, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL count_absent got %h want %h", v, 32'd0); end
    read_reg(5'd11, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL compare_absent got %h want %h", v, 32'd0); end
`endif
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer;
    logic [31:0] v;
    bit          seen;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      read_reg(5'd9, v);
      if (IntReq === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen || v !== 32'd6) begin
      errors++; $display("FAIL timer_irq got seen=%b count=%0d want seen=1 count=6", seen, v);
    end
    tick();
    read_reg(5'd13, v); checks++;
    if (v[15] !== 1'b1) begin errors++; $display("FAIL timer_ip7 got %b want 1", v[15]); end
    mtc0(5'd11, 32'hFFFF_FFFF);
    tick();
    read_reg(5'd13, v); checks++;
    if (v[15] !== 1'b0) begin errors++; $display("FAIL timer_ack got %b want 0", v[15]); end
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    #1; checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL timer_quiet got %b want 0", IntReq); end
  endtask
`endif

  task automatic test_reset_midrun;
    logic [31:0] v;
    ExcCode = 5'd10; VPC = 32'h7000;
    tick();
    ExcCode = 5'd5; HWInt = 6'h3F;
    #2;
    reset_n = 1'b0;
    #1; checks++;
    if (IntReq !== 1'b0 || EPC !== 32'd0) begin
      errors++; $display("FAIL midreset_out got intreq=%b epc=%h want 0/0", IntReq, EPC);
    end
    read_reg(5'd12, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL midreset_sr got %h want %h", v, 32'd0); end
    read_reg(5'd13, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL midreset_cause got %h want %h", v, 32'd0); end
    read_reg(5'd15, v); checks++;
    if (v !== PRID) begin errors++; $display("FAIL midreset_prid got %h want %h", v, PRID); end
    apply_reset();
  endtask

  // Reference model, kept as architectural register words.
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  logic        m_pend;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
`ifdef CP0_TIMER_EN
      5'd9:    return m_count;
      5'd11:   return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_random;
    logic [4:0]  codes [4] = '{5'd4, 5'd5, 5'd10, 5'd12};
    logic [4:0]  regs  [6] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    logic [5:0]  lines;
    logic        ih, eh, req, wr_ok;
    logic [31:0] nv, cnt_next;
    idle();
    reset_n = 1'b0;
    tick();
    m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_pend = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      A1      = ($urandom_range(0, 7) < 6) ? regs[$urandom_range(0, 5)] : 5'($urandom);
      A2      = ($urandom_range(0, 7) < 6) ? regs[$urandom_range(0, 5)] : 5'($urandom);
      Din     = $urandom;
      We      = ($urandom_range(0, 2) == 0);
      VPC     = $urandom;
      BD      = 1'($urandom);
      ExcCode = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 3)] : 5'd0;
      HWInt   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      EXLClr  = ($urandom_range(0, 3) == 0);
      #1;
      lines = HWInt;
`ifdef CP0_TIMER_EN
      lines[5] = HWInt[5] | m_pend;
`endif
      ih  = ((lines & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
      eh  = (ExcCode != 0) && !m_sr[1];
      req = ih || eh;
      checks++;
      if (IntReq !== req) begin errors++; $display("FAIL rand_intreq[%0d] got %b want %b", i, IntReq, req); end
      checks++;
      if (Dout !== model_read(A1)) begin
        errors++; $display("FAIL rand_dout[%0d] a1=%0d got %h want %h", i, A1, Dout, model_read(A1));
      end
      checks++;
      if (EPC !== m_epc) begin errors++; $display("FAIL rand_epc[%0d] got %h want %h", i, EPC, m_epc); end
      wr_ok    = We && !req;
      cnt_next = (wr_ok && A2 == 5'd9) ? Din : m_count + 32'd1;
      if (wr_ok && A2 == 5'd11) begin
        m_pend = 1'b0; m_compare = Din;
      end else begin
        m_pend = m_pend || (m_count == m_compare);
      end
      m_count = cnt_next;
      m_cause[15:10] = lines;
      if (req) begin
        m_sr[1]      = 1'b1;
        m_cause[31]  = BD;
        m_cause[6:2] = ih ? 5'd0 : ExcCode;
        nv           = BD ? VPC - 32'd4 : VPC;
        m_epc        = nv & ~32'd3;
      end else begin
        if (wr_ok && A2 == 5'd12) m_sr = Din & 32'h0000_FC03;
        if (wr_ok && A2 == 5'd14) m_epc = Din & ~32'd3;
        if (EXLClr) m_sr[1] = 1'b0;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    #12;
    test_reset();
    tick();
    reset_n = 1'b1;
    mtc0(5'd11, 32'hFFFF_FFFF);
    test_intr_entry();
    test_exc_bd();
    test_priority();
    test_eret_reentry();
    test_mtc0();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
